// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl
//   Wishbone-slave GPIO block: NUM_BUTTONS debounced buttons with sticky
//   rising-edge capture and a level interrupt, plus NUM_LEDS LED outputs with
//   per-bit output enable and per-bit blink.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   i_wb_cyc/stb/we/sel   Wishbone request qualifiers and byte selects
//   i_wb_addr/i_wb_data   byte address and write data
//   o_wb_ack/o_wb_data    single-cycle acknowledge and read data
//   buttons               raw asynchronous button inputs, active-high
//   leds                  LED drive
//   led_enb               pad output enable, active-low
//   irq                   level interrupt, |(BTN_EDGE & IRQ_EN), registered
//
// Handshake: a request is cyc & stb & ~ack with a base-address match. It is
// acknowledged exactly one cycle later for one cycle; the ack itself blocks
// the next request, so a master holding stb completes every two cycles.
// Writes and read-data capture both happen on the edge that raises ack.

module wb_gpio_ctrl #(
  parameter int          NUM_BUTTONS     = 3,
  parameter int          NUM_LEDS        = 8,
  parameter int          DEBOUNCE_CYCLES = 1000,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [3:0]             i_wb_sel,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  output logic                   o_wb_ack,
  output logic [31:0]            o_wb_data,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [NUM_LEDS-1:0]    led_enb,
  output logic                   irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_LED_DATA  = 3'd0;
  localparam logic [2:0] OFF_LED_OE    = 3'd1;
  localparam logic [2:0] OFF_LED_MODE  = 3'd2;
  localparam logic [2:0] OFF_BLINK_DIV = 3'd3;
  localparam logic [2:0] OFF_BTN_STATE = 3'd4;
  localparam logic [2:0] OFF_BTN_EDGE  = 3'd5;
  localparam logic [2:0] OFF_IRQ_EN    = 3'd6;

  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_LEDS-1:0]    led_data_q, led_data_d;
  logic [NUM_LEDS-1:0]    led_oe_q, led_oe_d;
  logic [NUM_LEDS-1:0]    led_mode_q, led_mode_d;
  logic [23:0]            blink_div_q, blink_div_d;
  logic [23:0]            presc_q, presc_d;
  logic                   phase_q, phase_d;
  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] deb_q, deb_d;
  logic [NUM_BUTTONS-1:0] edge_q, edge_d;
  logic [NUM_BUTTONS-1:0] irq_en_q, irq_en_d;
  logic [CW-1:0]          cnt_q [NUM_BUTTONS];
  logic [CW-1:0]          cnt_d [NUM_BUTTONS];
  logic                   irq_q, irq_d;
  logic [NUM_LEDS-1:0]    leds_q, leds_d;
  logic [NUM_LEDS-1:0]    led_enb_q, led_enb_d;

  logic                   req, wr;
  logic [2:0]             offs;
  logic [31:0]            rd_mux;
  logic [NUM_BUTTONS-1:0] edge_clr;

  // Address bits below the register window and byte-lane bits beyond the
  // implemented widths carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{i_wb_addr[7:5], i_wb_addr[1:0], i_wb_data, i_wb_sel};

  assign offs = i_wb_addr[4:2];
  assign req  = i_wb_cyc & i_wb_stb & ~ack_q & (i_wb_addr[31:8] == BASE_ADDR[31:8]);
  assign wr   = req & i_wb_we;

  // Bus side: read mux, ack, register writes with byte selects.
  always_comb begin
    rd_mux = '0;
    case (offs)
      OFF_LED_DATA:  rd_mux[NUM_LEDS-1:0]    = led_data_q;
      OFF_LED_OE:    rd_mux[NUM_LEDS-1:0]    = led_oe_q;
      OFF_LED_MODE:  rd_mux[NUM_LEDS-1:0]    = led_mode_q;
      OFF_BLINK_DIV: rd_mux[23:0]            = blink_div_q;
      OFF_BTN_STATE: rd_mux[NUM_BUTTONS-1:0] = deb_q;
      OFF_BTN_EDGE:  rd_mux[NUM_BUTTONS-1:0] = edge_q;
      OFF_IRQ_EN:    rd_mux[NUM_BUTTONS-1:0] = irq_en_q;
      default:       rd_mux                  = '0;
    endcase

    ack_d       = req;
    rdata_d     = (req && !i_wb_we) ? rd_mux : 32'h0;
    led_data_d  = led_data_q;
    led_oe_d    = led_oe_q;
    led_mode_d  = led_mode_q;
    blink_div_d = blink_div_q;
    irq_en_d    = irq_en_q;
    edge_clr    = '0;

    for (int i = 0; i < NUM_LEDS; i++) begin
      if (wr && i_wb_sel[i/8]) begin
        if (offs == OFF_LED_DATA) led_data_d[i] = i_wb_data[i];
        if (offs == OFF_LED_OE)   led_oe_d[i]   = i_wb_data[i];
        if (offs == OFF_LED_MODE) led_mode_d[i] = i_wb_data[i];
      end
    end
    for (int i = 0; i < 24; i++) begin
      if (wr && i_wb_sel[i/8] && offs == OFF_BLINK_DIV) blink_div_d[i] = i_wb_data[i];
    end
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (wr && i_wb_sel[i/8]) begin
        if (offs == OFF_IRQ_EN)   irq_en_d[i] = i_wb_data[i];
        if (offs == OFF_BTN_EDGE) edge_clr[i] = i_wb_data[i];
      end
    end
  end

  // Button path: two-flop synchroniser, stability counter, sticky edges.
  always_comb begin
    sync1_d = buttons;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // DEBOUNCE_CYCLES consecutive differing samples: accept the new level.
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // A rising edge in the same cycle as a write-1-to-clear must survive.
    edge_d = (edge_q & ~edge_clr) | (deb_d & ~deb_q);
    irq_d  = |(edge_q & irq_en_q);
  end

  // Blink prescaler and LED output stage.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if ((wr && offs == OFF_BLINK_DIV) || blink_div_q == 24'h0) begin
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == blink_div_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + 24'h1;
    end
    leds_d    = led_data_q & (~led_mode_q | {NUM_LEDS{phase_q}});
    led_enb_d = ~led_oe_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      led_data_q  <= '0;
      led_oe_q    <= '0;
      led_mode_q  <= '0;
      blink_div_q <= '0;
      presc_q     <= '0;
      phase_q     <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      edge_q      <= '0;
      irq_en_q    <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
      irq_q       <= 1'b0;
      leds_q      <= '0;
      led_enb_q   <= '1;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      led_data_q  <= led_data_d;
      led_oe_q    <= led_oe_d;
      led_mode_q  <= led_mode_d;
      blink_div_q <= blink_div_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      edge_q      <= edge_d;
      irq_en_q    <= irq_en_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
      irq_q       <= irq_d;
      leds_q      <= leds_d;
      led_enb_q   <= led_enb_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign leds      = leds_q;
  assign led_enb   = led_enb_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
module tb_wb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;
  logic [2:0]  buttons;
  logic [7:0]  leds, led_enb;
  logic        irq;

  wb_gpio_ctrl #(
    .NUM_BUTTONS(3), .NUM_LEDS(8), .DEBOUNCE_CYCLES(4), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .buttons(buttons), .leds(leds), .led_enb(led_enb), .irq(irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_q[$];       // expected read data, in issue order
  logic [31:0] exp_addr_q[$];  // address of each expected read, for messages
  logic        ack_exp_q[$];   // expected o_wb_ack at probed negedges
  logic [16:0] pin_q[$];       // expected {irq, led_enb, leds}
  logic        ack_probe = 1'b0;
  logic        pin_probe = 1'b0;
  logic        end_chk   = 1'b0;
  logic        end_done  = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic probe_ack(input logic exp_ack);
    ack_exp_q.push_back(exp_ack);
    ack_probe = 1'b1;
    #5;
    ack_probe = 1'b0;
  endtask

  // One Wishbone transfer: request edge, ack check after it, ack-drop check
  // one cycle later.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    if (!w && exp_ack) begin
      exp_q.push_back(exp_rd);
      exp_addr_q.push_back(a);
    end
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(posedge clk); #1;
    probe_ack(exp_ack);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    probe_ack(1'b0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    wb_xfer(1'b1, BASE + {24'h0, off}, s, d, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] e);
    wb_xfer(1'b0, BASE + {24'h0, off}, 4'hF, 32'h0, 1'b1, e);
  endtask

  task automatic check_pins(input logic [16:0] e);
    @(posedge clk); #1;
    pin_q.push_back(e);
    pin_probe = 1'b1;
    #5;
    pin_probe = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 8; i++) rd(8'(i * 4), 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && o_wb_ack && !we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected_ack addr=%h got=%h required=no ack", addr, o_wb_data);
      end else begin
        logic [31:0] e, a;
        e = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        if (o_wb_data !== e) begin
          errors++;
          $display("FAIL rd_data addr=%h got=%h required=%h", a, o_wb_data, e);
        end
      end
    end
    if (ack_probe) begin
      logic ea;
      ea = ack_exp_q.pop_front();
      vectors++;
      if (o_wb_ack !== ea) begin
        errors++;
        $display("FAIL ack addr=%h got=%b required=%b", addr, o_wb_ack, ea);
      end
    end
    if (pin_probe) begin
      logic [16:0] ep;
      ep = pin_q.pop_front();
      vectors++;
      if ({irq, led_enb, leds} !== ep) begin
        errors++;
        $display("FAIL pins {irq,led_enb,leds} got=%b_%h_%h required=%b_%h_%h",
                 irq, led_enb, leds, ep[16], ep[15:8], ep[7:0]);
      end
    end
    if (end_chk && !end_done) begin
      vectors++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_read_acks got=%0d outstanding required=0", exp_q.size());
      end
      end_done <= 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0; stb = 0; we = 0; sel = 0; addr = 0; wdata = 0;
    buttons = 3'b000; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    check_pins({1'b0, 8'hFF, 8'h00});
    read_all_zero();

    // LED data / output enable, byte selects, unmapped offset
    wr(8'h00, 4'hF, 32'h0000_00A5);
    wr(8'h04, 4'hF, 32'h0000_00FF);
    check_pins({1'b0, 8'h00, 8'hA5});
    wr(8'h00, 4'h0, 32'h0000_0000);
    rd(8'h00, 32'h0000_00A5);
    rd(8'h04, 32'h0000_00FF);
    wr(8'h0C, 4'b0001, 32'h0012_3456);
    rd(8'h0C, 32'h0000_0056);
    wr(8'h0C, 4'b0010, 32'hFFFF_FFFF);
    rd(8'h0C, 32'h0000_FF56);
    wr(8'h1C, 4'hF, 32'hFFFF_FFFF);
    rd(8'h1C, 32'h0);

    // Glitch of 3 cycles on button 0 is filtered
    @(posedge clk); #1 buttons = 3'b001;
    repeat (3) @(posedge clk);
    #1 buttons = 3'b000;
    repeat (12) @(posedge clk);
    rd(8'h10, 32'h0);
    rd(8'h14, 32'h0);

    // Button 0 held: still 0 after 5 edges, 1 after 6
    @(posedge clk); #1 buttons = 3'b001;
    repeat (4) @(posedge clk);
    rd(8'h10, 32'h0);
    repeat (2) @(posedge clk);
    rd(8'h10, 32'h1);
    rd(8'h14, 32'h1);

    // Button 1: read sampling the state right after the 6th edge
    @(posedge clk); #1 buttons = 3'b011;
    repeat (5) @(posedge clk);
    rd(8'h10, 32'h3);
    rd(8'h14, 32'h3);

    // Interrupt and write-1-to-clear
    wr(8'h18, 4'hF, 32'h1);
    rd(8'h18, 32'h1);
    check_pins({1'b1, 8'h00, 8'hA5});
    wr(8'h14, 4'hF, 32'h1);
    check_pins({1'b0, 8'h00, 8'hA5});
    rd(8'h14, 32'h2);

    // Falling debounced edge does not set BTN_EDGE
    @(posedge clk); #1 buttons = 3'b010;
    repeat (12) @(posedge clk);
    rd(8'h10, 32'h2);
    rd(8'h14, 32'h2);

    // Clear coinciding with a new rising edge: the set wins
    @(posedge clk); #1 buttons = 3'b011;
    repeat (4) @(posedge clk);
    wr(8'h14, 4'hF, 32'h1);
    rd(8'h14, 32'h3);
    check_pins({1'b1, 8'h00, 8'hA5});

    // Blink with BLINK_DIV=3: period 8, toggling every 4 cycles
    wr(8'h08, 4'hF, 32'h1);
    wr(8'h00, 4'hF, 32'h1);
    wr(8'h0C, 4'hF, 32'h3);
    for (int n = 0; n < 16; n++)
      check_pins({1'b1, 8'h00, 7'h0, (((n + 1) / 4) % 2) == 0});

    // BLINK_DIV=0 holds the LED on
    wr(8'h0C, 4'hF, 32'h0);
    for (int n = 0; n < 8; n++) check_pins({1'b1, 8'h00, 8'h01});

    // Address mismatch: neither read nor write acked, write ignored
    wb_xfer(1'b0, 32'h3000_0100, 4'hF, 32'h0, 1'b0, 32'h0);
    wb_xfer(1'b1, 32'h3000_0100, 4'hF, 32'hFF, 1'b0, 32'h0);
    rd(8'h00, 32'h1);

    // Reset asserted at the request edge: no ack, everything back to reset
    buttons = 3'b000;
    repeat (12) @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE; sel = 4'hF; wdata = 32'hFF;
    reset_n = 1'b0;
    @(posedge clk); #1;
    probe_ack(1'b0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    probe_ack(1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    check_pins({1'b0, 8'hFF, 8'h00});
    read_all_zero();

    // Drain and report
    repeat (5) @(posedge clk);
    end_chk = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
